// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default sizes for the memory-port arbiter
// and the cache instances that sit in front of it.
//   arb_state_t : arbiter sequencing states
//   client_t    : client identifier (icache = 0, dcache = 1)
//   DEF_*       : default line, write-data and address widths
package mem_arb_pkg;

  localparam int unsigned DEF_BLOCKSZ     = 512;
  localparam int unsigned DEF_WIDTH       = 64;
  localparam int unsigned DEF_ADDRESSSIZE = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    CL_IC = 1'b0,
    CL_DC = 1'b1
  } client_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin pick.
// Ports:
//   req_ic, req_dc : request bits of icache / dcache
//   last_grant     : client granted most recently
//   grant_valid    : at least one request present
//   grant_id       : chosen client (the one not granted last on a tie)
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic    req_ic,
  input  logic    req_dc,
  input  client_t last_grant,
  output logic    grant_valid,
  output client_t grant_id
);

  always_comb begin
    grant_valid = req_ic | req_dc;
    grant_id    = CL_IC;
    if (req_ic && req_dc) begin
      grant_id = (last_grant == CL_IC) ? CL_DC : CL_IC;
    end else if (req_dc) begin
      grant_id = CL_DC;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between icache (client 0) and
// dcache (client 1). One transaction at a time, round-robin on ties,
// per-transaction watchdog that aborts with an err pulse.
// Ports:
//   clk, rst             : clock, synchronous active-low reset
//   ic_req/ic_addr       : icache read request (level, held until ic_done)
//   ic_rdata/done/err    : registered block, completion and timeout pulses
//   dc_req/wr_en/addr/wdata : dcache read or write request
//   dc_rdata/done/err    : registered block, completion and timeout pulses
//   mem_req/address/wr_en/data_out : registered memory-port request
//   mem_data_in/valid    : memory response block and one-cycle strobe
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned BLOCKSZ     = DEF_BLOCKSZ,
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned ADDRESSSIZE = DEF_ADDRESSSIZE,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned CNTW        = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ic_req,
  input  logic [ADDRESSSIZE-1:0] ic_addr,
  output logic [BLOCKSZ-1:0]     ic_rdata,
  output logic                   ic_done,
  output logic                   ic_err,
  input  logic                   dc_req,
  input  logic                   dc_wr_en,
  input  logic [ADDRESSSIZE-1:0] dc_addr,
  input  logic [WIDTH-1:0]       dc_wdata,
  output logic [BLOCKSZ-1:0]     dc_rdata,
  output logic                   dc_done,
  output logic                   dc_err,
  output logic                   mem_req,
  output logic [ADDRESSSIZE-1:0] mem_address,
  output logic                   mem_wr_en,
  output logic [WIDTH-1:0]       mem_data_out,
  input  logic [BLOCKSZ-1:0]     mem_data_in,
  input  logic                   mem_data_valid
);

  arb_state_t             state_q, state_d;
  client_t                owner_q, owner_d;
  client_t                last_grant_q, last_grant_d;
  logic [CNTW-1:0]        wdog_q, wdog_d;
  logic                   mem_req_q, mem_req_d;
  logic [ADDRESSSIZE-1:0] addr_q, addr_d;
  logic                   wr_en_q, wr_en_d;
  logic [WIDTH-1:0]       wdata_q, wdata_d;
  logic [BLOCKSZ-1:0]     ic_rdata_q, ic_rdata_d;
  logic [BLOCKSZ-1:0]     dc_rdata_q, dc_rdata_d;
  logic                   ic_done_q, ic_done_d;
  logic                   ic_err_q, ic_err_d;
  logic                   dc_done_q, dc_done_d;
  logic                   dc_err_q, dc_err_d;

  logic    grant_valid;
  client_t grant_id;

  rr_pick2 u_pick (
    .req_ic      (ic_req),
    .req_dc      (dc_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Next-state, latch, watchdog and return-register logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wdog_d       = wdog_q;
    mem_req_d    = 1'b0;
    addr_d       = addr_q;
    wr_en_d      = wr_en_q;
    wdata_d      = wdata_q;
    ic_rdata_d   = ic_rdata_q;
    dc_rdata_d   = dc_rdata_q;
    ic_done_d    = 1'b0;
    ic_err_d     = 1'b0;
    dc_done_d    = 1'b0;
    dc_err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d      = grant_id;
          last_grant_d = grant_id;
          wdog_d       = '0;
          mem_req_d    = 1'b1;
          state_d      = BUSY;
          if (grant_id == CL_IC) begin
            addr_d  = ic_addr;
            wr_en_d = 1'b0;
            wdata_d = '0;
          end else begin
            addr_d  = dc_addr;
            wr_en_d = dc_wr_en;
            wdata_d = dc_wdata;
          end
        end
      end

      BUSY: begin
        mem_req_d = 1'b1;
        // A response on the final watchdog cycle still completes normally
        if (mem_data_valid) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
          if (owner_q == CL_IC) begin
            ic_rdata_d = mem_data_in;
            ic_done_d  = 1'b1;
          end else begin
            dc_rdata_d = mem_data_in;
            dc_done_d  = 1'b1;
          end
        end else if (wdog_q == CNTW'(TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
          if (owner_q == CL_IC) begin
            ic_rdata_d = '0;
            ic_done_d  = 1'b1;
            ic_err_d   = 1'b1;
          end else begin
            dc_rdata_d = '0;
            dc_done_d  = 1'b1;
            dc_err_d   = 1'b1;
          end
        end else begin
          wdog_d = wdog_q + CNTW'(1);
        end
      end

      // One-cycle bubble lets the owner drop req after seeing done
      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= CL_IC;
      last_grant_q <= CL_DC;
      wdog_q       <= '0;
      mem_req_q    <= 1'b0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wdata_q      <= '0;
      ic_rdata_q   <= '0;
      dc_rdata_q   <= '0;
      ic_done_q    <= 1'b0;
      ic_err_q     <= 1'b0;
      dc_done_q    <= 1'b0;
      dc_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wdog_q       <= wdog_d;
      mem_req_q    <= mem_req_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      wdata_q      <= wdata_d;
      ic_rdata_q   <= ic_rdata_d;
      dc_rdata_q   <= dc_rdata_d;
      ic_done_q    <= ic_done_d;
      ic_err_q     <= ic_err_d;
      dc_done_q    <= dc_done_d;
      dc_err_q     <= dc_err_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_address  = addr_q;
  assign mem_wr_en    = wr_en_q;
  assign mem_data_out = wdata_q;
  assign ic_rdata     = ic_rdata_q;
  assign ic_done      = ic_done_q;
  assign ic_err       = ic_err_q;
  assign dc_rdata     = dc_rdata_q;
  assign dc_done      = dc_done_q;
  assign dc_err       = dc_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table, hand sequences and a randomized run
// against a cycle-timeline reference model of the arbiter.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int unsigned BS = 512;
  localparam int unsigned W  = 64;
  localparam int unsigned AW = 64;
  localparam int unsigned T  = 8;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ic_req = 1'b0;
  logic [AW-1:0] ic_addr = '0;
  logic [BS-1:0] ic_rdata;
  logic          ic_done, ic_err;
  logic          dc_req = 1'b0;
  logic          dc_wr_en = 1'b0;
  logic [AW-1:0] dc_addr = '0;
  logic [W-1:0]  dc_wdata = '0;
  logic [BS-1:0] dc_rdata;
  logic          dc_done, dc_err;
  logic          mem_req;
  logic [AW-1:0] mem_address;
  logic          mem_wr_en;
  logic [W-1:0]  mem_data_out;
  logic [BS-1:0] mem_data_in = '0;
  logic          mem_data_valid = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter #(
    .BLOCKSZ(BS), .WIDTH(W), .ADDRESSSIZE(AW), .TIMEOUT(T), .CNTW(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata),
    .ic_done(ic_done), .ic_err(ic_err),
    .dc_req(dc_req), .dc_wr_en(dc_wr_en), .dc_addr(dc_addr),
    .dc_wdata(dc_wdata), .dc_rdata(dc_rdata),
    .dc_done(dc_done), .dc_err(dc_err),
    .mem_req(mem_req), .mem_address(mem_address), .mem_wr_en(mem_wr_en),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
    .mem_data_valid(mem_data_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; ic_req = 1'b0; dc_req = 1'b0; dc_wr_en = 1'b0; mem_data_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic        ic, dc, wr;
    logic [63:0] ia, da, wd;
    int          lat;        // BUSY cycle carrying mem_data_valid, 0 = never
    logic [31:0] pat;
    int          e_own;
    logic        e_wr;
    logic [63:0] e_addr, e_wd;
    logic        e_err;
  } row_t;

  row_t         tbl [8];
  row_t         r;
  logic [511:0] exp_rd [2];
  int           fin;

  // random-phase model state
  bit           m_act;
  int           m_g, m_lat, m_own, m_lastg, m_idle_at;
  logic [63:0]  m_addr, m_wd;
  logic         m_wr;
  logic [511:0] m_rd [2];
  bit           e_req;
  bit           e_done [2];
  bit           e_err [2];
  bit           w [2];
  bit           in_busy;

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    // Starts from reset: last grant is dcache, so icache wins the first tie
    tbl[0] = '{1'b1, 1'b0, 1'b0, 64'h1000, 64'h9999, 64'h1234,     5, 32'hA5A5A5A5, 0, 1'b0, 64'h1000, 64'h0,        1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 64'h7777, 64'h2008, 64'hDEADBEEF, 3, 32'h3C3C3C3C, 1, 1'b1, 64'h2008, 64'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 64'h3000, 64'h4000, 64'hCAFE,     2, 32'h11112222, 0, 1'b0, 64'h3000, 64'h0,        1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 64'h3040, 64'h4040, 64'h55,       1, 32'h33334444, 1, 1'b0, 64'h4040, 64'h55,       1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 64'h5000, 64'h6000, 64'h77,       0, 32'h55556666, 0, 1'b0, 64'h5000, 64'h0,        1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 64'h5100, 64'h6100, 64'hF00D,     8, 32'h77778888, 1, 1'b1, 64'h6100, 64'hF00D,     1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 64'h7000, 64'h0,    64'h0,        8, 32'h9999AAAA, 0, 1'b0, 64'h7000, 64'h0,        1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 64'h0,    64'h8000, 64'h0,        0, 32'hBBBBCCCC, 1, 1'b0, 64'h8000, 64'h0,        1'b1};

    // Reset state
    do_reset();
    chk("rst_mem_req", 512'(mem_req), 512'(0));
    chk("rst_mem_address", 512'(mem_address), 512'(0));
    chk("rst_mem_wr_en", 512'(mem_wr_en), 512'(0));
    chk("rst_mem_data_out", 512'(mem_data_out), 512'(0));
    chk("rst_pulses", 512'({ic_done, ic_err, dc_done, dc_err}), 512'(0));
    chk("rst_ic_rdata", ic_rdata, 512'(0));
    chk("rst_dc_rdata", dc_rdata, 512'(0));
    exp_rd[0] = '0;
    exp_rd[1] = '0;

    // Directed transaction table
    for (int i = 0; i < 8; i++) begin
      r = tbl[i];
      ic_req = r.ic; dc_req = r.dc; dc_wr_en = r.wr;
      ic_addr = r.ia; dc_addr = r.da; dc_wdata = r.wd;
      mem_data_in = {16{r.pat}};
      fin = (r.lat == 0) ? int'(T) : r.lat;
      for (int k = 1; k <= fin + 1; k++) begin
        @(negedge clk);
        mem_data_valid = 1'b0;
        if (k <= fin) begin
          chk("tbl_mem_req", 512'(mem_req), 512'(1));
          chk("tbl_mem_address", 512'(mem_address), 512'(r.e_addr));
          chk("tbl_mem_wr_en", 512'(mem_wr_en), 512'(r.e_wr));
          chk("tbl_mem_data_out", 512'(mem_data_out), 512'(r.e_wd));
          chk("tbl_early_done", 512'({ic_done, dc_done, ic_err, dc_err}), 512'(0));
          // client inputs wander while the port is held
          ic_addr = {$urandom, $urandom}; dc_addr = {$urandom, $urandom};
          dc_wdata = {$urandom, $urandom}; dc_wr_en = ~dc_wr_en;
          if (r.lat != 0 && k == r.lat) mem_data_valid = 1'b1;
        end else begin
          exp_rd[r.e_own] = r.e_err ? 512'(0) : {16{r.pat}};
          chk("tbl_done_mem_req", 512'(mem_req), 512'(0));
          chk("tbl_own_done", 512'(r.e_own != 0 ? dc_done : ic_done), 512'(1));
          chk("tbl_own_err", 512'(r.e_own != 0 ? dc_err : ic_err), 512'(r.e_err));
          chk("tbl_other_pulses", 512'(r.e_own != 0 ? {ic_done, ic_err} : {dc_done, dc_err}), 512'(0));
          chk("tbl_ic_rdata", ic_rdata, exp_rd[0]);
          chk("tbl_dc_rdata", dc_rdata, exp_rd[1]);
          ic_req = 1'b0; dc_req = 1'b0;
          // a late response after a timeout must be dropped
          if (r.e_err) begin
            mem_data_valid = 1'b1;
            mem_data_in = ~mem_data_in;
          end
        end
      end
      @(negedge clk);
      mem_data_valid = 1'b0;
      chk("tbl_idle_mem_req", 512'(mem_req), 512'(0));
      chk("tbl_idle_pulses", 512'({ic_done, dc_done, ic_err, dc_err}), 512'(0));
      chk("tbl_idle_ic_rdata", ic_rdata, exp_rd[0]);
      chk("tbl_idle_dc_rdata", dc_rdata, exp_rd[1]);
    end

    // Reset three cycles into BUSY aborts silently, held req re-granted
    dc_req = 1'b1; dc_wr_en = 1'b1; dc_addr = 64'hABC0; dc_wdata = 64'h99;
    @(negedge clk);
    chk("mr_busy", 512'(mem_req), 512'(1));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_mem_req", 512'(mem_req), 512'(0));
    chk("mr_mem_address", 512'(mem_address), 512'(0));
    chk("mr_mem_wr", 512'({mem_wr_en, mem_data_out}), 512'(0));
    chk("mr_pulses", 512'({ic_done, ic_err, dc_done, dc_err}), 512'(0));
    chk("mr_ic_rdata", ic_rdata, 512'(0));
    chk("mr_dc_rdata", dc_rdata, 512'(0));
    rst = 1'b1; dc_addr = 64'hABD0;
    @(negedge clk);
    chk("mr_regrant", 512'(mem_req), 512'(1));
    chk("mr_regrant_addr", 512'(mem_address), 512'(64'hABD0));
    chk("mr_regrant_wr", 512'(mem_wr_en), 512'(1));
    mem_data_in = {16{32'h0F0F1234}};
    mem_data_valid = 1'b1;
    @(negedge clk);
    mem_data_valid = 1'b0;
    chk("mr_dc_done", 512'({dc_done, dc_err}), 512'(2));
    chk("mr_dc_rdata_after", dc_rdata, {16{32'h0F0F1234}});
    dc_req = 1'b0;
    @(negedge clk);
    chk("mr_bubble", 512'(mem_req), 512'(0));

    // Both held from reset: I, D, I, D with a DONE bubble plus the IDLE
    // arbitration cycle between transactions
    do_reset();
    ic_req = 1'b1; dc_req = 1'b1; dc_wr_en = 1'b0;
    ic_addr = 64'h100; dc_addr = 64'h200;
    begin
      int ng, low, kb;
      ng = 0; low = 0; kb = 0;
      for (int cyc = 0; cyc < 60 && ng < 4; cyc++) begin
        @(negedge clk);
        mem_data_valid = 1'b0;
        if (mem_req) begin
          if (kb == 0) begin
            chk("rr_order", 512'(mem_address), (ng % 2 != 0) ? 512'(64'h200) : 512'(64'h100));
            if (ng > 0) chk("rr_gap", 512'(low), 512'(2));
            ng++;
          end
          kb++;
          if (kb == 2) mem_data_valid = 1'b1;
        end else begin
          if (kb != 0) begin
            kb = 0;
            low = 0;
          end
          low++;
        end
      end
      chk("rr_grants", 512'(ng), 512'(4));
    end

    // Randomized run against the timeline model
    do_reset();
    m_act = 0; m_g = 0; m_lat = 0; m_own = 0; m_lastg = 1; m_idle_at = 0;
    m_addr = '0; m_wd = '0; m_wr = 1'b0; m_rd[0] = '0; m_rd[1] = '0;
    e_req = 0; e_done[0] = 0; e_done[1] = 0; e_err[0] = 0; e_err[1] = 0;
    w[0] = 0; w[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge clk);
      chk("r_mem_req", 512'(mem_req), 512'(e_req));
      chk("r_mem_address", 512'(mem_address), 512'(m_addr));
      chk("r_mem_wr_en", 512'(mem_wr_en), 512'(m_wr));
      chk("r_mem_data_out", 512'(mem_data_out), 512'(m_wd));
      chk("r_ic_pulses", 512'({ic_done, ic_err}), 512'({e_done[0], e_err[0]}));
      chk("r_dc_pulses", 512'({dc_done, dc_err}), 512'({e_done[1], e_err[1]}));
      chk("r_ic_rdata", ic_rdata, m_rd[0]);
      chk("r_dc_rdata", dc_rdata, m_rd[1]);

      for (int i = 0; i < 2; i++) begin
        if (w[i] && e_done[i]) w[i] = ($urandom_range(3) == 0);
        else if (!w[i]) w[i] = ($urandom_range(3) == 0);
      end
      ic_req = w[0]; dc_req = w[1];
      ic_addr = {$urandom, $urandom}; dc_addr = {$urandom, $urandom};
      dc_wdata = {$urandom, $urandom}; dc_wr_en = 1'($urandom_range(1));
      mem_data_in = rand512();
      in_busy = m_act && (c > m_g);
      mem_data_valid = in_busy ? (c - m_g == m_lat) : ($urandom_range(9) == 0);
      rst = ($urandom_range(299) != 0);

      e_req = 0; e_done[0] = 0; e_done[1] = 0; e_err[0] = 0; e_err[1] = 0;
      if (!rst) begin
        m_act = 0; m_lastg = 1; m_idle_at = c + 1;
        m_addr = '0; m_wd = '0; m_wr = 1'b0; m_rd[0] = '0; m_rd[1] = '0;
      end else if (m_act) begin
        if (mem_data_valid) begin
          m_rd[m_own] = mem_data_in; e_done[m_own] = 1; m_act = 0; m_idle_at = c + 2;
        end else if (c - m_g == int'(T)) begin
          m_rd[m_own] = '0; e_done[m_own] = 1; e_err[m_own] = 1; m_act = 0; m_idle_at = c + 2;
        end else begin
          e_req = 1;
        end
      end else if (c >= m_idle_at && (ic_req || dc_req)) begin
        m_own = (ic_req && dc_req) ? 1 - m_lastg : (ic_req ? 0 : 1);
        m_lastg = m_own; m_act = 1; m_g = c; m_lat = int'($urandom_range(T + 2, 1));
        m_addr = (m_own != 0) ? dc_addr : ic_addr;
        m_wr = (m_own != 0) ? dc_wr_en : 1'b0;
        m_wd = (m_own != 0) ? dc_wdata : 64'h0;
        e_req = 1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
